// File: rtl/dense_argmax_collector.sv
// dense_argmax_collector
//   Collects one inference's worth of Dense-layer results into a small buffer.
//   It also tracks the running signed maximum and its index, which is the
//   predicted class. The buffer can be read back through a registered port.
//
// Ports
//   clk       clock, rising edge
//   rst       synchronous active-high reset
//   start     1-cycle pulse: clear results and arm a new inference
//   inValid   Dense valid, one result word per cycle while high
//   inData    Dense result word (two's complement)
//   rdAdr     buffer read address
//   rdData    buffer word at rdAdr, one cycle latency; 0 for rdAdr >= OUT_COUNT
//   busy      high while collecting
//   done      high once all OUT_COUNT words are captured (level)
//   count     words captured in the current inference
//   classIdx  index of the maximum word
//   maxVal    value of the maximum word
//   overrun   sticky: a word arrived after the inference was already complete
module dense_argmax_collector #(
    parameter int OUT_COUNT = 3,
    parameter int DATA_SIZE = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           inValid,
    input  logic [DATA_SIZE-1:0]           inData,
    input  logic [$clog2(OUT_COUNT)-1:0]   rdAdr,
    output logic [DATA_SIZE-1:0]           rdData,
    output logic                           busy,
    output logic                           done,
    output logic [$clog2(OUT_COUNT+1)-1:0] count,
    output logic [$clog2(OUT_COUNT)-1:0]   classIdx,
    output logic [DATA_SIZE-1:0]           maxVal,
    output logic                           overrun
);

    localparam int AW = $clog2(OUT_COUNT);
    localparam int CW = $clog2(OUT_COUNT + 1);
    localparam logic [CW-1:0] LAST = CW'(OUT_COUNT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t state;

    logic [DATA_SIZE-1:0] buf_mem [OUT_COUNT];

    // A word is accepted only while collecting; start in the same cycle drops it.
    logic capture;
    assign capture = (state == COLLECT) && inValid && !start;

    // Control, flags and running maximum.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            overrun  <= 1'b0;
            count    <= '0;
            classIdx <= '0;
            maxVal   <= '0;
        end else if (start) begin
            state    <= COLLECT;
            busy     <= 1'b1;
            done     <= 1'b0;
            overrun  <= 1'b0;
            count    <= '0;
            classIdx <= '0;
            maxVal   <= '0;
        end else begin
            case (state)
                COLLECT: begin
                    if (inValid) begin
                        count <= count + 1'b1;
                        // Strict '>' keeps the lowest index on ties.
                        if (count == '0 || $signed(inData) > $signed(maxVal)) begin
                            maxVal   <= inData;
                            classIdx <= count[AW-1:0];
                        end
                        if (count == LAST) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (inValid) begin
                        overrun <= 1'b1;
                    end
                end
                default: begin
                    // IDLE: input words are ignored.
                end
            endcase
        end
    end

    // Result buffer is not reset; it is always written before it is meaningful.
    always_ff @(posedge clk) begin
        if (capture) begin
            buf_mem[count[AW-1:0]] <= inData;
        end
    end

    // Registered read port; a same-edge write is not forwarded (old data returned).
    always_ff @(posedge clk) begin
        if (rst) begin
            rdData <= '0;
        end else if (32'(rdAdr) < OUT_COUNT) begin
            rdData <= buf_mem[rdAdr];
        end else begin
            rdData <= '0;
        end
    end

endmodule

// File: tb/tb_dense_argmax_collector.sv
// tb_dense_argmax_collector
//   Directed self-checking bench for dense_argmax_collector (OUT_COUNT=3,
//   DATA_SIZE=8). Inputs change 1 ns after a rising edge. Outputs are sampled
//   at that same point, so every value is read away from the clock edge.
module tb_dense_argmax_collector;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       inValid = 1'b0;
    logic [7:0] inData = '0;
    logic [1:0] rdAdr = '0;
    logic [7:0] rdData;
    logic       busy;
    logic       done;
    logic [1:0] count;
    logic [1:0] classIdx;
    logic [7:0] maxVal;
    logic       overrun;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dense_argmax_collector #(.OUT_COUNT(3), .DATA_SIZE(8)) dut (
        .clk(clk), .rst(rst), .start(start), .inValid(inValid), .inData(inData),
        .rdAdr(rdAdr), .rdData(rdData), .busy(busy), .done(done), .count(count),
        .classIdx(classIdx), .maxVal(maxVal), .overrun(overrun)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] d);
        inValid = 1'b1;
        inData  = d;
        step();
        inValid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        checks++;
        if ({busy, done, overrun} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags busy/done/overrun got %b%b%b want 000", busy, done, overrun);
        end
        checks++;
        if (count !== 2'd0 || classIdx !== 2'd0 || maxVal !== 8'h00) begin
            failures++;
            $display("FAIL reset_values count=%0d classIdx=%0d maxVal=%h want 0/0/00", count, classIdx, maxVal);
        end
        checks++;
        if (rdData !== 8'h00) begin
            failures++;
            $display("FAIL reset_rdData got %h want 00", rdData);
        end
        // A word in IDLE is ignored and raises no flag.
        send(8'h55);
        checks++;
        if (busy !== 1'b0 || count !== 2'd0 || overrun !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL idle_ignore busy=%b count=%0d overrun=%b done=%b want 0/0/0/0", busy, count, overrun, done);
        end
    endtask

    task automatic test_back_to_back();
        pulse_start();
        checks++;
        if (busy !== 1'b1 || count !== 2'd0) begin
            failures++;
            $display("FAIL b2b_armed busy=%b count=%0d want 1/0", busy, count);
        end
        inValid = 1'b1;
        inData = 8'h05; step();
        inData = 8'h7F; step();
        checks++;
        if (busy !== 1'b1 || count !== 2'd2 || done !== 1'b0) begin
            failures++;
            $display("FAIL b2b_mid busy=%b count=%0d done=%b want 1/2/0", busy, count, done);
        end
        inData = 8'h10; step();
        inValid = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || count !== 2'd3 || classIdx !== 2'd1 || maxVal !== 8'h7F) begin
            failures++;
            $display("FAIL b2b_result done=%b busy=%b count=%0d classIdx=%0d maxVal=%h want 1/0/3/1/7f",
                     done, busy, count, classIdx, maxVal);
        end
        rdAdr = 2'd2;
        step();
        checks++;
        if (rdData !== 8'h10) begin
            failures++;
            $display("FAIL b2b_read2 got %h want 10", rdData);
        end
        rdAdr = 2'd3;
        step();
        checks++;
        if (rdData !== 8'h00) begin
            failures++;
            $display("FAIL read_out_of_range got %h want 00", rdData);
        end
    endtask

    task automatic test_overrun();
        send(8'h7E);
        checks++;
        if (overrun !== 1'b1 || classIdx !== 2'd1 || maxVal !== 8'h7F || count !== 2'd3 || done !== 1'b1) begin
            failures++;
            $display("FAIL overrun_flag overrun=%b classIdx=%0d maxVal=%h count=%0d done=%b want 1/1/7f/3/1",
                     overrun, classIdx, maxVal, count, done);
        end
        step();
        checks++;
        if (overrun !== 1'b1) begin
            failures++;
            $display("FAIL overrun_sticky got %b want 1", overrun);
        end
        rdAdr = 2'd0;
        step();
        checks++;
        if (rdData !== 8'h05) begin
            failures++;
            $display("FAIL overrun_buf0 got %h want 05", rdData);
        end
        pulse_start();
        checks++;
        if (overrun !== 1'b0 || done !== 1'b0 || count !== 2'd0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL overrun_clear overrun=%b done=%b count=%0d busy=%b want 0/0/0/1", overrun, done, count, busy);
        end
    endtask

    task automatic test_signed_gaps();
        pulse_start();
        send(8'hF0);
        step();
        checks++;
        if (count !== 2'd1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL gap_hold1 count=%0d busy=%b want 1/1", count, busy);
        end
        send(8'h80);
        step();
        checks++;
        if (count !== 2'd2 || classIdx !== 2'd0 || maxVal !== 8'hF0) begin
            failures++;
            $display("FAIL gap_hold2 count=%0d classIdx=%0d maxVal=%h want 2/0/f0", count, classIdx, maxVal);
        end
        send(8'hFF);
        checks++;
        if (done !== 1'b1 || classIdx !== 2'd2 || maxVal !== 8'hFF || count !== 2'd3) begin
            failures++;
            $display("FAIL signed_result done=%b classIdx=%0d maxVal=%h count=%0d want 1/2/ff/3",
                     done, classIdx, maxVal, count);
        end
    endtask

    task automatic test_tie();
        pulse_start();
        rdAdr = 2'd0;
        // buf[0] holds F0 from the previous run; same-edge read returns it.
        send(8'h20);
        checks++;
        if (rdData !== 8'hF0) begin
            failures++;
            $display("FAIL read_during_write got %h want f0", rdData);
        end
        send(8'h20);
        send(8'h10);
        checks++;
        if (classIdx !== 2'd0 || maxVal !== 8'h20 || done !== 1'b1) begin
            failures++;
            $display("FAIL tie_result classIdx=%0d maxVal=%h done=%b want 0/20/1", classIdx, maxVal, done);
        end
    endtask

    task automatic test_restart_abort();
        pulse_start();
        send(8'h40);
        start = 1'b1;
        inValid = 1'b1;
        inData = 8'h7F;
        step();
        start = 1'b0;
        inValid = 1'b0;
        checks++;
        if (count !== 2'd0 || busy !== 1'b1 || maxVal !== 8'h00 || classIdx !== 2'd0) begin
            failures++;
            $display("FAIL restart_clear count=%0d busy=%b maxVal=%h classIdx=%0d want 0/1/00/0",
                     count, busy, maxVal, classIdx);
        end
        send(8'h01);
        send(8'h02);
        send(8'h03);
        checks++;
        if (classIdx !== 2'd2 || maxVal !== 8'h03 || count !== 2'd3 || done !== 1'b1) begin
            failures++;
            $display("FAIL restart_result classIdx=%0d maxVal=%h count=%0d done=%b want 2/03/3/1",
                     classIdx, maxVal, count, done);
        end
        rdAdr = 2'd0;
        step();
        checks++;
        if (rdData !== 8'h01) begin
            failures++;
            $display("FAIL restart_buf0 got %h want 01", rdData);
        end
        pulse_start();
        send(8'h11);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || count !== 2'd0 || maxVal !== 8'h00) begin
            failures++;
            $display("FAIL abort busy=%b done=%b count=%0d maxVal=%h want 0/0/0/00", busy, done, count, maxVal);
        end
        // Back in IDLE: further words must not be captured.
        send(8'h22);
        checks++;
        if (count !== 2'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_idle count=%0d busy=%b want 0/0", count, busy);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_back_to_back();
        test_overrun();
        test_signed_gaps();
        test_tie();
        test_restart_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
